mdu: RTL and testbench

Multiply/divide unit for the MIPS datapath. Takes the two register-file read operands (rs, rt), runs signed/unsigned multiply or divide over a fixed multi-cycle latency, and holds the results in the architectural HI/LO registers. Provides `mfhi`/`mflo` read data back toward the register-file write-back path, and a stall request for the hazard unit. Also services `mthi`/`mtlo` writes.

---
 rtl/mdu.sv | 175 +++++++++++++++++
 tb/tb_mdu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and committed after a fixed latency.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        hl_sel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] rd
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_p_hi;
    logic [31:0]    r_p_lo;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;

    logic           w_idle;
    logic           w_accept;
    logic           w_wr_ok;
    logic           w_commit;
    logic           w_is_div;

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic               w_div0;
    logic               w_ovf;
    logic        [31:0] w_res_hi;
    logic        [31:0] w_res_lo;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && start;
    assign w_wr_ok  = w_idle && !start;
    assign w_commit = (r_state == S_RUN) && (r_cnt == ONE);
    assign w_is_div = op[1];

    assign w_a_s    = $signed(A);
    assign w_b_s    = $signed(B);
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_div0   = (B == 32'd0);
    assign w_ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Divide-by-zero and overflow are special-cased below, so the
    // raw quotient/remainder only matter for well-defined operands.
    assign w_quo_s  = w_a_s / w_b_s;
    assign w_rem_s  = w_a_s % w_b_s;
    assign w_quo_u  = A / B;
    assign w_rem_u  = A % B;

    // Select the result for the requested operation.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        unique case (op)
            2'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'd2: begin
                if (w_div0) begin
                    w_res_hi = A;
                    w_res_lo = 32'hFFFF_FFFF;
                end else if (w_ovf) begin
                    w_res_hi = 32'd0;
                    w_res_lo = 32'h8000_0000;
                end else begin
                    w_res_hi = w_rem_s;
                    w_res_lo = w_quo_s;
                end
            end
            default: begin
                if (w_div0) begin
                    w_res_hi = A;
                    w_res_lo = 32'hFFFF_FFFF;
                end else begin
                    w_res_hi = w_rem_u;
                    w_res_lo = w_quo_u;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: launch on start in IDLE, return after last busy cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start)    w_next = S_RUN;
            S_RUN:   if (w_commit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs derived from state.
    always_comb begin
        busy      = (r_state == S_RUN);
        stall_req = (r_state == S_RUN) | start;
    end

    // Latency counter and pending result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_p_hi <= 32'd0;
            r_p_lo <= 32'd0;
        end else if (w_accept) begin
            r_cnt  <= w_is_div ? DIV_N : MULT_N;
            r_p_hi <= w_res_hi;
            r_p_lo <= w_res_lo;
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt - ONE;
        end
    end

    // Architectural HI/LO: commit or direct writes when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            r_hi <= r_p_hi;
            r_lo <= r_p_lo;
        end else if (w_wr_ok) begin
            if (wr_hi) r_hi <= A;
            if (wr_lo) r_lo <= A;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;
    assign rd = hl_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven and sequence checks for the mdu block.
// Expected HI/LO are queued at issue and compared at completion.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [1:0]  op;
    logic        wr_hi;
    logic        wr_lo;
    logic        hl_sel;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] rd;

    mdu dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .start     (start),
        .op        (op),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .hl_sel    (hl_sel),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO),
        .rd        (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t vecs[10];
    res_t sb[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        res_t r;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            r = sb.pop_front();
            check({name, ".HI"}, HI, r.hi);
            check({name, ".LO"}, LO, r.lo);
        end
    endtask

    task automatic count_busy(output int bc);
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int n);
        int bc;
        res_t r;
        A = a; B = b; op = o; start = 1'b1;
        r.hi = eh; r.lo = el;
        sb.push_back(r);
        #1;
        check({name, ".stall"}, {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        count_busy(bc);
        check({name, ".busy_cycles"}, bc, n);
        pop_check(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int   bc;
        int   idle_bc;
        res_t r;
        logic [31:0] prior_lo;

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; A = '0; B = '0; start = 1'b0; op = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; hl_sel = 1'b0;

        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10};
        vecs[4] = '{2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10};
        vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
        vecs[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 10};
        vecs[7] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5};
        vecs[9] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10};

        @(negedge clk);
        do_reset();
        check("rst.HI", HI, 32'd0);
        check("rst.LO", LO, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);

        A = 32'h1234_5678; wr_hi = 1'b1;
        @(negedge clk);
        wr_hi = 1'b0; hl_sel = 1'b1;
        #1;
        check("wr_hi.HI", HI, 32'h1234_5678);
        check("wr_hi.rd", rd, 32'h1234_5678);
        check("wr_hi.LO", LO, 32'd0);
        hl_sel = 1'b0;
        @(negedge clk);

        A = 32'd100; B = 32'd3; op = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.HI", HI, 32'd0);
        check("abort.LO", LO, 32'd0);
        idle_bc = 0;
        for (int i = 0; i < 15; i++) begin
            if (busy) idle_bc++;
            @(negedge clk);
        end
        check("abort.no_busy", idle_bc, 0);
        check("abort.late_HI", HI, 32'd0);
        check("abort.late_LO", LO, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n);
            @(negedge clk);
        end

        prior_lo = LO;
        A = 32'd3; B = 32'd4; op = 2'd0; start = 1'b1;
        r.hi = 32'd0; r.lo = 32'd12;
        sb.push_back(r);
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy && bc < 200) begin
            bc++;
            hl_sel = 1'b0;
            #1;
            check($sformatf("ign.rd%0d", bc), rd, prior_lo);
            if (bc == 2) begin
                start = 1'b1; op = 2'd2; wr_lo = 1'b1; A = 32'hDEAD;
            end else begin
                start = 1'b0; wr_lo = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_lo = 1'b0;
        check("ign.busy_cycles", bc, 5);
        pop_check("ign");
        idle_bc = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) idle_bc++;
            @(negedge clk);
        end
        check("ign.no_extra_busy", idle_bc, 0);
        check("ign.LO_hold", LO, 32'd12);

        A = 32'd2; B = 32'd3; op = 2'd1; start = 1'b1; wr_hi = 1'b1;
        r.hi = 32'd0; r.lo = 32'd6;
        sb.push_back(r);
        #1;
        check("sim.stall", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        count_busy(bc);
        check("sim.busy_cycles", bc, 5);
        pop_check("sim");
        @(negedge clk);

        A = 32'd5; B = 32'd6; op = 2'd1; start = 1'b1;
        r.hi = 32'd0; r.lo = 32'd30;
        sb.push_back(r);
        @(negedge clk);
        A = 32'd7; B = 32'd8;
        count_busy(bc);
        check("b2b.first_cycles", bc, 5);
        check("b2b.gap_busy", {31'd0, busy}, 32'd0);
        pop_check("b2b1");
        r.hi = 32'd0; r.lo = 32'd56;
        sb.push_back(r);
        @(negedge clk);
        check("b2b.second_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        count_busy(bc);
        check("b2b.second_cycles", bc, 5);
        pop_check("b2b2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
